memory_stage: RTL and testbench
===============================

// Module: memory_stage
// PURPOSE
// - Pipeline M stage. Sits between execute and writeback and drives writeback's *_m inputs.
// - Registers the execute-stage bundle and performs the data-memory access over a req/ready handshake.
// - Formats load data by funct3 and registers the result bundle (M/W register) for writeback.
// - Stalls upstream while a memory access is outstanding.
// PARAMETERS
// - ADDRESS_WIDTH  32  width of pc_plus4 and dmem_addr
// - DATA_WIDTH     32  datapath width; fixed at 32 (byte lanes derived for 32 only)
// PORTS
// - clk            in   1   sole clock, rising edge
// - rst_n          in   1   asynchronous, active-low reset
// - valid_e        in   1   execute bundle valid this cycle
// - reg_write_e    in   1   instr writes rd
// - result_src_e   in   2   00 alu, 01 load data, 10 pc+4
// - mem_write_e    in   1   store
// - funct3_e       in   3   load/store size: 000 B, 001 H, 010 W, 100 BU, 101 HU
// - alu_result_e   in   DW  effective address / ALU result
// - write_data_e   in   DW  store data (rs2)
// - rd_e           in   5   destination register
// - pc_plus4_e     in   AW  pc+4
// - stall_m        out  1   hold execute bundle; E inputs stay stable while high
// - dmem_req       out  1   memory request
// - dmem_we        out  1   write enable
// - dmem_addr      out  AW  word-aligned address ({addr[AW-1:2],2'b00})
// - dmem_be        out  4   byte enables
// - dmem_wdata     out  DW  lane-replicated store data
// - dmem_ready     in   1   request accepted/completed this cycle; dmem_rdata valid with it
// - dmem_rdata     in   DW  read word
// - reg_write_m    out  1   to writeback
// - result_src_m   out  2   to writeback
// - alu_result_m   out  DW  to writeback
// - read_data_m    out  DW  formatted load data
// - rd_m           out  5   to writeback
// - pc_plus4_m     out  AW  to writeback
// - misalign_m     out  1   one-cycle pulse: misaligned access dropped
// BEHAVIOUR
// - Reset (async, rst_n=0): all registers 0, state IDLE, dmem_req=0, stall_m=0, all *_m outputs 0,
//   misalign_m=0. Applies immediately, including mid-access; the pending access is abandoned.
// - Capture: on each edge with stall_m=0, the E/M register loads the E bundle.
//   valid_e=0 loads a bubble (reg_write=0, mem_write=0, result_src=00).
// - mem op = captured valid and (result_src==01 or mem_write).
// - Misaligned: H with addr[0]=1, or W with addr[1:0]!=0. No request issued; reg_write_m=0 at output;
//   misalign_m=1 for one cycle.
// - FSM IDLE/ACCESS:
//   - IDLE -> ACCESS on capture of an aligned mem op.
//   - In ACCESS, dmem_req=1 with addr/we/be/wdata held stable.
//   - dmem_ready=1 -> M/W register loads, state returns IDLE (or stays ACCESS if the newly captured
//     instr is an aligned mem op).
//   - stall_m = (state==ACCESS) & ~dmem_ready.
// - Latency: non-mem instr reaches *_m one edge after capture. A mem op with ready in its first
//   ACCESS cycle has no stall; each ready=0 cycle adds one stall cycle.
// - While stalled, the M/W register loads a bubble (reg_write_m=0), so writeback never double-writes.
// - Stores: SB be=4'b0001<<addr[1:0], wdata={4{wd[7:0]}}; SH be=addr[1]?1100:0011, wdata={2{wd[15:0]}};
//   SW be=1111.
// - Loads: select lane by addr[1:0]. B/H sign-extend; BU/HU zero-extend; W passthrough.
//   Non-load: read_data_m=0.
// - Undefined funct3 on a mem op: treated as W.
// TESTING
// - ALU op (rd=5, alu=0x1234, src=00), no mem -> 1 cycle later reg_write_m=1, rd_m=5, alu_result_m=0x1234;
//   dmem_req never 1.
// - LB addr=0x103, rdata=0x80FF_0000, ready immediate -> read_data_m=0xFFFF_FF80, stall_m never 1.
// - LHU addr=0x102, rdata=0xBEEF_0000, ready after 3 cycles -> stall_m=1 for 3 cycles, addr 0x100 held;
//   read_data_m=0x0000_BEEF.
// - SB addr=0x201, wd=0xAB -> dmem_we=1, be=0010, wdata=0xABAB_ABAB; reg_write_m=0.
// - LW addr=0x102 -> no dmem_req, misalign_m pulses 1 cycle, reg_write_m=0.
// - rst_n low during ACCESS with ready=0 -> dmem_req, stall_m and all *_m drop to 0 immediately;
//   after release, a fresh ALU op completes normally.

Source files
------------

// File: rtl/memory_stage.sv
// Pipeline M stage: registers the execute bundle, runs the data-memory req/ready access,
// formats load data by funct3 and registers the result bundle for writeback.
module memory_stage #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     valid_e,
    input  logic                     reg_write_e,
    input  logic [1:0]               result_src_e,
    input  logic                     mem_write_e,
    input  logic [2:0]               funct3_e,
    input  logic [DATA_WIDTH-1:0]    alu_result_e,
    input  logic [DATA_WIDTH-1:0]    write_data_e,
    input  logic [4:0]               rd_e,
    input  logic [ADDRESS_WIDTH-1:0] pc_plus4_e,
    output logic                     stall_m,
    output logic                     dmem_req,
    output logic                     dmem_we,
    output logic [ADDRESS_WIDTH-1:0] dmem_addr,
    output logic [3:0]               dmem_be,
    output logic [DATA_WIDTH-1:0]    dmem_wdata,
    input  logic                     dmem_ready,
    input  logic [DATA_WIDTH-1:0]    dmem_rdata,
    output logic                     reg_write_m,
    output logic [1:0]               result_src_m,
    output logic [DATA_WIDTH-1:0]    alu_result_m,
    output logic [DATA_WIDTH-1:0]    read_data_m,
    output logic [4:0]               rd_m,
    output logic [ADDRESS_WIDTH-1:0] pc_plus4_m,
    output logic                     misalign_m
);
    localparam int AW = ADDRESS_WIDTH;
    localparam int DW = DATA_WIDTH;

    typedef enum logic {IDLE, ACCESS} state_t;

    typedef struct packed {
        logic          valid;
        logic          reg_write;
        logic [1:0]    result_src;
        logic          mem_write;
        logic [2:0]    funct3;
        logic [DW-1:0] alu_result;
        logic [DW-1:0] write_data;
        logic [4:0]    rd;
        logic [AW-1:0] pc_plus4;
    } em_t;

    typedef struct packed {
        logic          reg_write;
        logic [1:0]    result_src;
        logic [DW-1:0] alu_result;
        logic [DW-1:0] read_data;
        logic [4:0]    rd;
        logic [AW-1:0] pc_plus4;
        logic          misalign;
    } mw_t;

    state_t state_q, state_d;
    em_t    em_q, em_d, in_b;
    mw_t    mw_q, mw_d;
    logic   in_aligned_mem, em_mem, em_mis;

    // funct3[1:0]: 00 byte, 01 half, anything else is handled as a word.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   is_misaligned = 1'b0;
            2'b01:   is_misaligned = a[0];
            default: is_misaligned = (a != 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   byte_en = 4'b0001 << a;
            2'b01:   byte_en = a[1] ? 4'b1100 : 4'b0011;
            default: byte_en = 4'b1111;
        endcase
    endfunction

    function automatic logic [DW-1:0] store_data(input logic [2:0] f3, input logic [DW-1:0] wd);
        case (f3[1:0])
            2'b00:   store_data = {4{wd[7:0]}};
            2'b01:   store_data = {2{wd[15:0]}};
            default: store_data = wd;
        endcase
    endfunction

    function automatic logic [DW-1:0] load_format(input logic [2:0] f3, input logic [1:0] a,
                                                  input logic [DW-1:0] rdata);
        logic [DW-1:0] lane;
        logic [7:0]    b;
        logic [15:0]   h;
        lane = rdata >> {a, 3'b000};
        b    = lane[7:0];
        h    = a[1] ? rdata[31:16] : rdata[15:0];
        case (f3[1:0])
            2'b00:   load_format = f3[2] ? {{(DW-8){1'b0}}, b} : {{(DW-8){b[7]}}, b};
            2'b01:   load_format = f3[2] ? {{(DW-16){1'b0}}, h} : {{(DW-16){h[15]}}, h};
            default: load_format = rdata;
        endcase
    endfunction

    assign stall_m = (state_q == ACCESS) && !dmem_ready;

    // Incoming bundle with control zeroed for bubbles.
    always_comb begin
        in_b            = '0;
        in_b.valid      = valid_e;
        in_b.reg_write  = valid_e & reg_write_e;
        in_b.result_src = valid_e ? result_src_e : 2'b00;
        in_b.mem_write  = valid_e & mem_write_e;
        in_b.funct3     = funct3_e;
        in_b.alu_result = alu_result_e;
        in_b.write_data = write_data_e;
        in_b.rd         = rd_e;
        in_b.pc_plus4   = pc_plus4_e;
        in_aligned_mem  = in_b.valid && (in_b.result_src == 2'b01 || in_b.mem_write)
                          && !is_misaligned(funct3_e, alu_result_e[1:0]);
        em_d            = stall_m ? em_q : in_b;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_aligned_mem) state_d = ACCESS;
            ACCESS:  if (dmem_ready) state_d = in_aligned_mem ? ACCESS : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // An aligned mem op in E/M always means ACCESS, so IDLE only sees non-mem, misaligned or bubbles.
    always_comb begin
        em_mem = em_q.valid && (em_q.result_src == 2'b01 || em_q.mem_write);
        em_mis = em_mem && is_misaligned(em_q.funct3, em_q.alu_result[1:0]);
        mw_d   = '0;
        if (!stall_m) begin
            mw_d.reg_write  = em_q.reg_write & ~em_mis;
            mw_d.result_src = em_q.result_src;
            mw_d.alu_result = em_q.alu_result;
            mw_d.rd         = em_q.rd;
            mw_d.pc_plus4   = em_q.pc_plus4;
            mw_d.misalign   = em_mis;
            if (state_q == ACCESS && em_q.result_src == 2'b01)
                mw_d.read_data = load_format(em_q.funct3, em_q.alu_result[1:0], dmem_rdata);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            em_q    <= '0;
            mw_q    <= '0;
        end else begin
            state_q <= state_d;
            em_q    <= em_d;
            mw_q    <= mw_d;
        end
    end

    assign dmem_req     = (state_q == ACCESS);
    assign dmem_we      = em_q.mem_write;
    assign dmem_addr    = {em_q.alu_result[AW-1:2], 2'b00};
    assign dmem_be      = byte_en(em_q.funct3, em_q.alu_result[1:0]);
    assign dmem_wdata   = store_data(em_q.funct3, em_q.write_data);

    assign reg_write_m  = mw_q.reg_write;
    assign result_src_m = mw_q.result_src;
    assign alu_result_m = mw_q.alu_result;
    assign read_data_m  = mw_q.read_data;
    assign rd_m         = mw_q.rd;
    assign pc_plus4_m   = mw_q.pc_plus4;
    assign misalign_m   = mw_q.misalign;
endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: table of single instructions plus hand-written
// back-to-back and reset-during-access sequences.
module tb_memory_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_e, reg_write_e, mem_write_e;
    logic [1:0]  result_src_e;
    logic [2:0]  funct3_e;
    logic [31:0] alu_result_e, write_data_e, pc_plus4_e;
    logic [4:0]  rd_e;
    logic        stall_m, dmem_req, dmem_we, dmem_ready;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        reg_write_m, misalign_m;
    logic [1:0]  result_src_m;
    logic [31:0] alu_result_m, read_data_m, pc_plus4_m;
    logic [4:0]  rd_m;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    memory_stage dut (
        .clk(clk), .rst_n(rst_n), .valid_e(valid_e), .reg_write_e(reg_write_e),
        .result_src_e(result_src_e), .mem_write_e(mem_write_e), .funct3_e(funct3_e),
        .alu_result_e(alu_result_e), .write_data_e(write_data_e), .rd_e(rd_e),
        .pc_plus4_e(pc_plus4_e), .stall_m(stall_m), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata), .reg_write_m(reg_write_m),
        .result_src_m(result_src_m), .alu_result_m(alu_result_m), .read_data_m(read_data_m),
        .rd_m(rd_m), .pc_plus4_m(pc_plus4_m), .misalign_m(misalign_m)
    );

    typedef struct {
        logic        v, rw;
        logic [1:0]  src;
        logic        mw;
        logic [2:0]  f3;
        logic [31:0] alu, wd;
        logic [4:0]  rd;
        logic [31:0] pc, rdata;
        int          dly;
        logic        x_req;
        logic [3:0]  x_be;
        logic [31:0] x_wdata;
        logic        x_rw;
        logic [31:0] x_rdm;
        logic        x_mis;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t t);
        valid_e = t.v; reg_write_e = t.rw; result_src_e = t.src; mem_write_e = t.mw;
        funct3_e = t.f3; alu_result_e = t.alu; write_data_e = t.wd; rd_e = t.rd;
        pc_plus4_e = t.pc;
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_vec(input int n, input vec_t t);
        logic [31:0] waddr;
        waddr = {t.alu[31:2], 2'b00};
        @(negedge clk);
        drive(t);
        tick();
        valid_e = 1'b0;
        chk($sformatf("v%0d req", n), dmem_req, t.x_req);
        if (t.x_req) begin
            chk($sformatf("v%0d we", n), dmem_we, t.mw);
            chk($sformatf("v%0d be", n), dmem_be, t.x_be);
            if (t.mw) chk($sformatf("v%0d wdata", n), dmem_wdata, t.x_wdata);
            for (int i = 0; i <= t.dly; i++) begin
                chk($sformatf("v%0d addr%0d", n, i), dmem_addr, waddr);
                if (i > 0) begin
                    chk($sformatf("v%0d req_held%0d", n, i), dmem_req, 1);
                    chk($sformatf("v%0d rw_bubble%0d", n, i), reg_write_m, 0);
                end
                dmem_ready = (i == t.dly);
                dmem_rdata = t.rdata;
                #1;
                chk($sformatf("v%0d stall%0d", n, i), stall_m, (i < t.dly) ? 1 : 0);
                tick();
            end
            dmem_ready = 1'b0;
            dmem_rdata = 32'h0;
        end else begin
            chk($sformatf("v%0d stall", n), stall_m, 0);
            tick();
        end
        chk($sformatf("v%0d rw_m", n), reg_write_m, t.x_rw);
        chk($sformatf("v%0d rdata_m", n), read_data_m, t.x_rdm);
        chk($sformatf("v%0d mis_m", n), misalign_m, t.x_mis);
        chk($sformatf("v%0d src_m", n), result_src_m, t.v ? t.src : 2'b00);
        if (t.v) begin
            chk($sformatf("v%0d rd_m", n), rd_m, t.rd);
            chk($sformatf("v%0d alu_m", n), alu_result_m, t.alu);
            chk($sformatf("v%0d pc_m", n), pc_plus4_m, t.pc);
        end
        tick();
        chk($sformatf("v%0d mis_clear", n), misalign_m, 0);
        chk($sformatf("v%0d rw_clear", n), reg_write_m, 0);
    endtask

    initial begin
        vec_t ld;
        //              v  rw src   mw f3      alu           wd            rd    pc      rdata         dly req be       wdata         rw rdm           mis
        vecs[0]  = '{1, 1, 2'b00, 0, 3'b000, 32'h1234,     32'h0,        5'd5, 32'h44, 32'h0,        0, 0, 4'b0000, 32'h0,        1, 32'h0,        0};
        vecs[1]  = '{1, 1, 2'b01, 0, 3'b000, 32'h103,      32'h0,        5'd7, 32'h48, 32'h80FF0000, 0, 1, 4'b1000, 32'h0,        1, 32'hFFFFFF80, 0};
        vecs[2]  = '{1, 1, 2'b01, 0, 3'b101, 32'h102,      32'h0,        5'd8, 32'h4C, 32'hBEEF0000, 3, 1, 4'b1100, 32'h0,        1, 32'h0000BEEF, 0};
        vecs[3]  = '{1, 0, 2'b00, 1, 3'b000, 32'h201,      32'hAB,       5'd0, 32'h50, 32'h0,        1, 1, 4'b0010, 32'hABABABAB, 0, 32'h0,        0};
        vecs[4]  = '{1, 1, 2'b01, 0, 3'b010, 32'h102,      32'h0,        5'd9, 32'h54, 32'h0,        0, 0, 4'b0000, 32'h0,        0, 32'h0,        1};
        vecs[5]  = '{1, 1, 2'b01, 0, 3'b001, 32'h101,      32'h0,        5'd9, 32'h58, 32'h0,        0, 0, 4'b0000, 32'h0,        0, 32'h0,        1};
        vecs[6]  = '{1, 1, 2'b01, 0, 3'b001, 32'h102,      32'h0,        5'd3, 32'h5C, 32'h80010000, 0, 1, 4'b1100, 32'h0,        1, 32'hFFFF8001, 0};
        vecs[7]  = '{1, 1, 2'b01, 0, 3'b010, 32'h100,      32'h0,        5'd4, 32'h60, 32'hDEADBEEF, 2, 1, 4'b1111, 32'h0,        1, 32'hDEADBEEF, 0};
        vecs[8]  = '{1, 0, 2'b00, 1, 3'b001, 32'h302,      32'h12345678, 5'd0, 32'h64, 32'h0,        0, 1, 4'b1100, 32'h56785678, 0, 32'h0,        0};
        vecs[9]  = '{1, 0, 2'b00, 1, 3'b010, 32'h304,      32'hCAFEF00D, 5'd0, 32'h68, 32'h0,        1, 1, 4'b1111, 32'hCAFEF00D, 0, 32'h0,        0};
        vecs[10] = '{1, 1, 2'b01, 0, 3'b100, 32'h101,      32'h0,        5'd6, 32'h6C, 32'h00009A00, 0, 1, 4'b0010, 32'h0,        1, 32'h0000009A, 0};
        vecs[11] = '{1, 1, 2'b10, 0, 3'b000, 32'h5,        32'h0,        5'd1, 32'h88, 32'h0,        0, 0, 4'b0000, 32'h0,        1, 32'h0,        0};
        vecs[12] = '{1, 1, 2'b01, 0, 3'b011, 32'h104,      32'h0,        5'd2, 32'h70, 32'h11223344, 0, 1, 4'b1111, 32'h0,        1, 32'h11223344, 0};
        vecs[13] = '{1, 1, 2'b01, 0, 3'b011, 32'h106,      32'h0,        5'd2, 32'h74, 32'h0,        0, 0, 4'b0000, 32'h0,        0, 32'h0,        1};
        vecs[14] = '{0, 1, 2'b01, 1, 3'b010, 32'h200,      32'h0,        5'd2, 32'h78, 32'h0,        0, 0, 4'b0000, 32'h0,        0, 32'h0,        0};
        vecs[15] = '{1, 0, 2'b00, 1, 3'b000, 32'h203,      32'h1FF,      5'd0, 32'h7C, 32'h0,        0, 1, 4'b1000, 32'hFFFFFFFF, 0, 32'h0,        0};

        rst_n = 1'b0; valid_e = 0; reg_write_e = 0; result_src_e = 0; mem_write_e = 0;
        funct3_e = 0; alu_result_e = 0; write_data_e = 0; rd_e = 0; pc_plus4_e = 0;
        dmem_ready = 0; dmem_rdata = 0;
        tick();
        tick();
        chk("rst req", dmem_req, 0);
        chk("rst stall", stall_m, 0);
        chk("rst rw_m", reg_write_m, 0);
        chk("rst mis_m", misalign_m, 0);
        chk("rst alu_m", alu_result_m, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) run_vec(i, vecs[i]);

        // Back-to-back loads, ready immediate: ACCESS must continue without a stall.
        ld = vecs[7];
        ld.alu = 32'h100;
        drive(ld);
        tick();
        ld.alu = 32'h104;
        drive(ld);
        dmem_ready = 1'b1; dmem_rdata = 32'hA5A5_0001;
        #1;
        chk("b2b stall0", stall_m, 0);
        chk("b2b addr0", dmem_addr, 32'h100);
        tick();
        valid_e = 1'b0;
        dmem_rdata = 32'h5A5A_0002;
        chk("b2b data0", read_data_m, 32'hA5A50001);
        chk("b2b req1", dmem_req, 1);
        chk("b2b addr1", dmem_addr, 32'h104);
        tick();
        dmem_ready = 1'b0;
        chk("b2b data1", read_data_m, 32'h5A5A0002);
        chk("b2b idle", dmem_req, 0);

        // Reset asserted mid-access abandons it immediately.
        tick();
        ld.alu = 32'h100;
        drive(ld);
        tick();
        valid_e = 1'b0;
        tick();
        chk("mid req", dmem_req, 1);
        chk("mid stall", stall_m, 1);
        rst_n = 1'b0;
        #1;
        chk("arst req", dmem_req, 0);
        chk("arst stall", stall_m, 0);
        chk("arst rw_m", reg_write_m, 0);
        chk("arst rdata_m", read_data_m, 0);
        chk("arst pc_m", pc_plus4_m, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(100, vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
